// File: rtl/svf_voice_scheduler.sv
// svf_voice_scheduler: time-multiplexed SVF filter bank; define SVF_SAT_EN for saturating arithmetic
module svf_voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int VW         = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sample_tick,
   input  logic [11:0]   x_in,
   input  logic          cfg_we,
   input  logic [VW-1:0] cfg_voice,
   input  logic [1:0]    cfg_sel,
   input  logic [11:0]   cfg_wdata,
   output logic          out_valid,
   output logic [VW-1:0] out_voice,
   output logic [11:0]   out_data,
   output logic          mix_valid,
   output logic [11:0]   mix_data,
   output logic          busy,
   output logic          overrun
);
`ifdef SVF_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   localparam int AW = 12 + VW;
   typedef enum logic [1:0] {IDLE, LOAD, CALC, MIX} state_t;
   state_t st, st_n;
   logic [VW-1:0] v;
   logic signed [11:0] x_q;
   logic signed [11:0] yb [NUM_VOICES];
   logic signed [11:0] yl [NUM_VOICES];
   logic signed [11:0] sf [NUM_VOICES];
   logic signed [11:0] sq [NUM_VOICES];
   logic [1:0] sm [NUM_VOICES];
   logic signed [11:0] nf [NUM_VOICES];
   logic signed [11:0] nq [NUM_VOICES];
   logic [1:0] nm [NUM_VOICES];
   logic signed [11:0] af [NUM_VOICES];
   logic signed [11:0] aq [NUM_VOICES];
   logic [1:0] am [NUM_VOICES];
   logic [NUM_VOICES-1:0] sup;
   logic signed [11:0] ryb, ryl, rf, rq;
   logic [1:0] rm;
   logic signed [11:0] qb, yh_n, yb_n, yl_n, yn_n, sel_y;
   logic signed [AW-1:0] acc;
   logic go, last, cmd;

   function automatic logic signed [11:0] fit(input logic signed [15:0] s);
      fit = (!SAT || s[15:11] == {5{s[15]}}) ? s[11:0] : {s[15], {11{~s[15]}}};
   endfunction

   function automatic logic signed [11:0] r(input logic signed [11:0] a, input logic signed [11:0] b);
      r = 12'((24'(a) * 24'(b)) >>> 12);
   endfunction

   assign go   = st == IDLE && sample_tick;
   assign last = v == VW'(NUM_VOICES - 1);
   assign cmd  = cfg_we && cfg_sel == 2'd3;

   // shadow registers after this cycle's write, so a write alongside a tick is copied too
   always_comb begin
      nf = sf;
      nq = sq;
      nm = sm;
      if (cfg_we && cfg_sel == 2'd0) nf[cfg_voice] = cfg_wdata;
      if (cfg_we && cfg_sel == 2'd1) nq[cfg_voice] = cfg_wdata;
      if (cfg_we && cfg_sel == 2'd2) nm[cfg_voice] = cfg_wdata[1:0];
   end

   // shadow writes every cycle; active set only refreshed on an accepted tick
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            sf[i] <= '0;
            sq[i] <= '0;
            sm[i] <= '0;
            af[i] <= '0;
            aq[i] <= '0;
            am[i] <= '0;
         end
      end else begin
         sf <= nf;
         sq <= nq;
         sm <= nm;
         if (go) begin
            af <= nf;
            aq <= nq;
            am <= nm;
         end
      end
   end

   // one filter step for the voice registered in LOAD
   always_comb begin
      qb    = r(rq, ryb);
      yh_n  = fit(16'(x_q) - 16'(ryl) - 16'(qb));
      yb_n  = fit(16'(r(rf, yh_n)) + 16'(ryb));
      yl_n  = fit(16'(r(rf, yb_n)) + 16'(ryl));
      yn_n  = fit(16'(yh_n) + 16'(yl_n));
      sel_y = rm == 2'd0 ? yl_n : rm == 2'd1 ? yb_n : rm == 2'd2 ? yh_n : yn_n;
   end

   // voice state write-back; a clear wins over a same-cycle store and blocks later stores this frame
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            yb[i] <= '0;
            yl[i] <= '0;
         end
         sup <= '0;
      end else begin
         if (go) sup <= '0;
         if (st == CALC && !sup[v]) begin
            yb[v] <= yb_n;
            yl[v] <= yl_n;
         end
         if (cmd && cfg_wdata[1]) begin
            yb[cfg_voice] <= '0;
            yl[cfg_voice] <= '0;
            if (st != IDLE) sup[cfg_voice] <= 1'b1;
         end
      end
   end

   // sample capture, per-voice operand registers and mix accumulator
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= '0;
         ryb <= '0;
         ryl <= '0;
         rf  <= '0;
         rq  <= '0;
         rm  <= '0;
         acc <= '0;
      end else begin
         if (go) begin
            x_q <= x_in;
            acc <= '0;
         end
         if (st == LOAD) begin
            ryb <= yb[v];
            ryl <= yl[v];
            rf  <= af[v];
            rq  <= aq[v];
            rm  <= am[v];
         end
         if (st == CALC) acc <= acc + AW'(sel_y);
      end
   end

   // state register, voice counter and sticky overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= IDLE;
         v       <= '0;
         overrun <= 1'b0;
      end else begin
         st      <= st_n;
         v       <= go ? '0 : (st == CALC && !last) ? v + VW'(1) : v;
         overrun <= (sample_tick && st != IDLE) || (overrun && !(cmd && cfg_wdata[0]));
      end
   end

   // next state and frame outputs
   always_comb begin
      st_n = st;
      case (st)
         IDLE: st_n = sample_tick ? LOAD : IDLE;
         LOAD: st_n = CALC;
         CALC: st_n = last ? MIX : LOAD;
         MIX:  st_n = IDLE;
         default: st_n = IDLE;
      endcase
      out_valid = st == CALC;
      out_voice = st == CALC ? v : '0;
      out_data  = st == CALC ? sel_y : '0;
      mix_valid = st == MIX;
      mix_data  = fit(16'(acc >>> VW));
      busy      = st != IDLE;
   end
endmodule

// File: tb/tb_svf_voice_scheduler.sv
// tb_svf_voice_scheduler: scoreboard bench for the SVF voice scheduler
module tb_svf_voice_scheduler;
   logic clk = 0, rst = 1, sample_tick = 0, cfg_we = 0;
   logic [11:0] x_in = 0, cfg_wdata = 0;
   logic [1:0] cfg_voice = 0, cfg_sel = 0;
   logic out_valid, mix_valid, busy, overrun;
   logic [1:0] out_voice;
   logic [11:0] out_data, mix_data;

   svf_voice_scheduler #(.NUM_VOICES(4), .VW(2)) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .x_in(x_in),
      .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
      .out_valid(out_valid), .out_voice(out_voice), .out_data(out_data),
      .mix_valid(mix_valid), .mix_data(mix_data), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {bit mix; int cyc; logic [1:0] voice; logic [11:0] data;} exp_t;
   exp_t q[$];
   exp_t em;
   int checks = 0, errors = 0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   // scoreboard monitor: every presented result is matched against the queue head
   always @(negedge clk) begin
      if (!rst && (out_valid || mix_valid)) begin
         if (q.size() == 0) chk("unexpected_output", {30'd0, mix_valid, out_valid}, 0);
         else begin
            em = q.pop_front();
            chk("kind", {31'd0, mix_valid}, {31'd0, em.mix});
            chk("cycle", cyc, em.cyc);
            if (em.mix) chk("mix_data", {20'd0, mix_data}, {20'd0, em.data});
            else begin
               chk("out_voice", {30'd0, out_voice}, {30'd0, em.voice});
               chk("out_data", {20'd0, out_data}, {20'd0, em.data});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int vc, input int sel, input int d);
      cfg_we = 1;
      cfg_voice = vc[1:0];
      cfg_sel = sel[1:0];
      cfg_wdata = d[11:0];
      step();
      cfg_we = 0;
   endtask

   task automatic clear_all();
      for (int i = 0; i < 4; i++) cfg(i, 3, 2);
   endtask

   task automatic tick(input logic [11:0] x, input logic [11:0] e0, input logic [11:0] e1,
                       input logic [11:0] e2, input logic [11:0] e3, input logic [11:0] m);
      logic [11:0] e [4];
      e = '{e0, e1, e2, e3};
      sample_tick = 1;
      x_in = x;
      for (int i = 0; i < 4; i++) q.push_back('{1'b0, cyc + 2 + 2 * i, i[1:0], e[i]});
      q.push_back('{1'b1, cyc + 9, 2'd0, m});
      step();
      sample_tick = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 0);
      step();
   endtask

   task automatic frame(input logic [11:0] x, input logic [11:0] e0, input logic [11:0] e1,
                        input logic [11:0] e2, input logic [11:0] e3, input logic [11:0] m);
      tick(x, e0, e1, e2, e3, m);
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] ev [4];
      logic [11:0] evm [4];
      ev  = '{12'h010, 12'h040, 12'h100, 12'h110};
      evm = '{12'h004, 12'h010, 12'h040, 12'h044};
      repeat (3) step();
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_mix_valid", {31'd0, mix_valid}, 0);
      chk("rst_out_data", {20'd0, out_data}, 0);
      chk("rst_mix_data", {20'd0, mix_data}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_overrun", {31'd0, overrun}, 0);
      rst = 0;
      step();
      frame(12'h000, 0, 0, 0, 0, 0);
      cfg(0, 0, 'h400);
      for (int m = 0; m < 4; m++) begin
         cfg(0, 2, m);
         cfg(0, 3, 2);
         frame(12'h100, ev[m], 0, 0, 0, evm[m]);
      end
      for (int i = 1; i < 4; i++) cfg(i, 0, 'h400);
      cfg(0, 2, 0);
      clear_all();
      frame(12'h100, 12'h010, 12'h010, 12'h010, 12'h010, 12'h010);
      clear_all();
      tick(12'h100, 12'h010, 12'h010, 12'h010, 12'h010, 12'h010);
      step();
      step();
      sample_tick = 1;
      x_in = 12'h7FF;
      step();
      sample_tick = 0;
      chk("overrun_set", {31'd0, overrun}, 1);
      chk("busy_in_frame", {31'd0, busy}, 1);
      wait_idle();
      chk("overrun_sticky", {31'd0, overrun}, 1);
      cfg(0, 3, 1);
      chk("overrun_clear", {31'd0, overrun}, 0);
      cfg(1, 0, 0);
      clear_all();
      tick(12'h100, 12'h010, 12'h000, 12'h010, 12'h010, 12'h00C);
      cfg(1, 0, 'h400);
      wait_idle();
      clear_all();
      frame(12'h100, 12'h010, 12'h010, 12'h010, 12'h010, 12'h010);
      clear_all();
      cfg_we = 1;
      cfg_voice = 2;
      cfg_sel = 0;
      cfg_wdata = 0;
      tick(12'h100, 12'h010, 12'h010, 12'h000, 12'h010, 12'h00C);
      cfg_we = 0;
      wait_idle();
      sample_tick = 1;
      x_in = 12'h100;
      step();
      sample_tick = 0;
      rst = 1;
      step();
      rst = 0;
      chk("abort_busy", {31'd0, busy}, 0);
      repeat (12) step();
      frame(12'h100, 0, 0, 0, 0, 0);
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
